// File: rtl/ofdm_cp_inserter.sv
// Cyclic-prefix inserter: buffers one NFFT-sample symbol, then emits its last NCP samples
// followed by the whole symbol, NSYM times per go. Optional CP flag outputs under CP_FLAG_EN.
module ofdm_cp_inserter #(
    parameter int DW   = 16,
    parameter int NFFT = 64,
    parameter int NCP  = 16,
    parameter int NSYM = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          go,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
`ifdef CP_FLAG_EN
    output logic          out_cp,
    output logic          out_sos,
`endif
    output logic          done
);

    localparam int AW = (NFFT > 1) ? $clog2(NFFT) : 1;
    localparam int SW = (NSYM > 1) ? $clog2(NSYM) : 1;
    localparam logic [AW-1:0] PTR_LAST = AW'(NFFT - 1);
    localparam logic [AW-1:0] CP_START = (NCP >= NFFT) ? '0 : AW'(NFFT - NCP);
    localparam logic [SW-1:0] SYM_LAST = SW'(NSYM - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_LOAD,
        S_CP,
        S_BODY,
        S_NEXT,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] samp_cnt_q, samp_cnt_d;
    logic [SW-1:0] sym_cnt_q, sym_cnt_d;
    logic [DW-1:0] mem_q [NFFT];
    logic          mem_we;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            samp_cnt_q <= '0;
            sym_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            samp_cnt_q <= samp_cnt_d;
            sym_cnt_q  <= sym_cnt_d;
        end
    end

    // NOTE: the sample buffer has no reset; every entry is written in LOAD before CP/BODY reads it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        samp_cnt_d = samp_cnt_q;
        sym_cnt_d  = sym_cnt_q;
        mem_we     = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_data   = '0;
        busy       = 1'b0;
        done       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                busy       = 1'b1;
                wr_ptr_d   = '0;
                rd_ptr_d   = '0;
                samp_cnt_d = '0;
                sym_cnt_d  = '0;
                state_d    = S_LOAD;
            end
            S_LOAD: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                if (in_valid) begin
                    mem_we     = 1'b1;
                    wr_ptr_d   = ptr_inc(wr_ptr_q);
                    samp_cnt_d = ptr_inc(samp_cnt_q);
                    if (wr_ptr_q == PTR_LAST) begin
                        rd_ptr_d = CP_START;
                        state_d  = S_CP;
                    end
                end
            end
            S_CP: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = mem_q[rd_ptr_q];
                if (out_ready) begin
                    rd_ptr_d = ptr_inc(rd_ptr_q);
                    if (rd_ptr_q == PTR_LAST) begin
                        state_d = S_BODY;
                    end
                end
            end
            S_BODY: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = mem_q[rd_ptr_q];
                if (out_ready) begin
                    rd_ptr_d   = ptr_inc(rd_ptr_q);
                    samp_cnt_d = ptr_inc(samp_cnt_q);
                    if (rd_ptr_q == PTR_LAST) begin
                        state_d = S_NEXT;
                    end
                end
            end
            S_NEXT: begin
                busy = 1'b1;
                if (sym_cnt_q == SYM_LAST) begin
                    state_d = S_DONE;
                end else begin
                    sym_cnt_d  = sym_cnt_q + SW'(1);
                    wr_ptr_d   = '0;
                    samp_cnt_d = '0;
                    state_d    = S_LOAD;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef CP_FLAG_EN
    // Within CP the read pointer visits CP_START only once, on the first prefix sample.
    assign out_cp  = (state_q == S_CP);
    assign out_sos = (state_q == S_CP) && (rd_ptr_q == CP_START);
`endif

endmodule

// File: tb/tb_ofdm_cp_inserter.sv
// Scoreboard bench for ofdm_cp_inserter: two configurations (NFFT=8/NCP=2/NSYM=3 and NCP=NFFT=4/NSYM=2).
`timescale 1ns/1ps
module tb_ofdm_cp_inserter;

    localparam int DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          cp;
        logic          sos;
    } exp_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    for (genvar g = 0; g < 2; g++) begin : gen_cfg
        localparam int NFFT = (g == 0) ? 8 : 4;
        localparam int NCP  = (g == 0) ? 2 : 4;
        localparam int NSYM = (g == 0) ? 3 : 2;
        localparam int LAT  = 1 + NSYM * (2 * NFFT + NCP + 1);

        logic          reset, go, in_valid, in_ready, out_valid, out_ready, busy, done;
        logic [DW-1:0] in_data, out_data;
        logic          out_cp, out_sos;
        logic          fin = 1'b0;
        exp_t          exp_q[$];
        logic [DW-1:0] in_q[$];
        bit            gap_en = 1'b0, bp_en = 1'b0, lat_en = 1'b0;
        int            cyc = 0, out_cnt = 0, done_cnt = 0, start_cyc = 0;
        logic          busy_prev = 1'b0, xfer_in = 1'b0;

        ofdm_cp_inserter #(.DW(DW), .NFFT(NFFT), .NCP(NCP), .NSYM(NSYM)) u_dut (
            .clk      (clk),
            .reset    (reset),
            .go       (go),
            .in_data  (in_data),
            .in_valid (in_valid),
            .in_ready (in_ready),
            .out_data (out_data),
            .out_valid(out_valid),
            .out_ready(out_ready),
            .busy     (busy),
`ifdef CP_FLAG_EN
            .out_cp   (out_cp),
            .out_sos  (out_sos),
`endif
            .done     (done)
        );

`ifndef CP_FLAG_EN
        assign out_cp  = 1'b0;
        assign out_sos = 1'b0;
`endif

        initial forever begin
            @(posedge clk);
            cyc++;
        end

        // Source and sink handshakes, updated 1 ns after each rising edge.
        initial begin
            in_valid  = 1'b0;
            in_data   = '0;
            out_ready = 1'b0;
            forever begin
                @(posedge clk);
                #1;
                if (xfer_in && in_q.size() > 0) void'(in_q.pop_front());
                in_valid  = (in_q.size() > 0) && !(gap_en && (cyc % 3 == 0));
                in_data   = (in_q.size() > 0) ? in_q[0] : '0;
                out_ready = !bp_en || cyc[0];
            end
        end

        // Monitor: compares every presented output against the scoreboard head.
        initial forever begin
            @(negedge clk);
            xfer_in = in_valid && in_ready;
            if (!reset) begin
                if (busy && !busy_prev) start_cyc = cyc;
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        check($sformatf("c%0d unexpected_output", g), 32'(out_data), 32'hFFFF_FFFF);
                    end else begin
                        check($sformatf("c%0d out_data[%0d]", g, out_cnt), 32'(out_data), 32'(exp_q[0].data));
`ifdef CP_FLAG_EN
                        check($sformatf("c%0d out_cp[%0d]", g, out_cnt), 32'(out_cp), 32'(exp_q[0].cp));
                        check($sformatf("c%0d out_sos[%0d]", g, out_cnt), 32'(out_sos), 32'(exp_q[0].sos));
`endif
                        if (out_ready) begin
                            void'(exp_q.pop_front());
                            out_cnt++;
                        end
                    end
                end else begin
`ifdef CP_FLAG_EN
                    check($sformatf("c%0d out_cp_idle", g), 32'({out_cp, out_sos}), 32'd0);
`endif
                end
                if (done) begin
                    done_cnt++;
                    check($sformatf("c%0d busy_at_done", g), 32'(busy), 32'd0);
                    if (lat_en) check($sformatf("c%0d go_to_done_latency", g), 32'(cyc - start_cyc), 32'(LAT));
                end
            end
            busy_prev = busy;
        end

        task automatic push_frame(input int base);
            for (int s = 0; s < NSYM; s++) begin
                for (int k = 0; k < NFFT; k++) in_q.push_back(DW'(base + s * NFFT + k));
                for (int k = NFFT - NCP; k < NFFT; k++)
                    exp_q.push_back(exp_t'{DW'(base + s * NFFT + k), 1'b1, (k == NFFT - NCP)});
                for (int k = 0; k < NFFT; k++)
                    exp_q.push_back(exp_t'{DW'(base + s * NFFT + k), 1'b0, 1'b0});
            end
        endtask

        task automatic pulse_go();
            @(posedge clk);
            #2 go = 1'b1;
            @(posedge clk);
            #2 go = 1'b0;
        endtask

        task automatic run_frame(input int base, input bit go_in_load);
            int d0;
            out_cnt = 0;
            d0 = done_cnt;
            push_frame(base);
            pulse_go();
            if (go_in_load) begin
                @(posedge clk);
                pulse_go();
            end
            for (int i = 0; i < 3000 && done_cnt == d0; i++) @(posedge clk);
            repeat (4) @(posedge clk);
            check($sformatf("c%0d done_count", g), 32'(done_cnt - d0), 32'd1);
            check($sformatf("c%0d out_count", g), 32'(out_cnt), 32'(NSYM * (NCP + NFFT)));
            check($sformatf("c%0d leftover_expected", g), 32'(exp_q.size()), 32'd0);
            check($sformatf("c%0d leftover_input", g), 32'(in_q.size()), 32'd0);
        endtask

        initial begin
            int d0;
            reset = 1'b1;
            go    = 1'b0;
            repeat (2) @(posedge clk);
            #2;
            check($sformatf("c%0d reset_outputs", g),
                  32'({in_ready, out_valid, busy, done, out_cp, out_sos}), 32'd0);
            check($sformatf("c%0d reset_out_data", g), 32'(out_data), 32'd0);
            reset = 1'b0;

            lat_en = 1'b1;
            run_frame(0, 1'b0);
            lat_en = 1'b0;

            bp_en = 1'b1;
            run_frame(100, 1'b0);
            bp_en = 1'b0;

            gap_en = 1'b1;
            run_frame(200, 1'b1);
            gap_en = 1'b0;

            // Abort in the middle of the second symbol's body.
            out_cnt = 0;
            d0 = done_cnt;
            push_frame(300);
            pulse_go();
            for (int i = 0; i < 3000 && out_cnt < (NFFT + NCP) + NCP + NFFT / 2; i++) @(negedge clk);
            @(posedge clk);
            #1;
            check($sformatf("c%0d valid_before_abort", g), 32'({out_valid, busy}), 32'd3);
            #1 reset = 1'b1;
            exp_q.delete();
            in_q.delete();
            #1;
            check($sformatf("c%0d async_reset_outputs", g),
                  32'({out_valid, in_ready, busy, done}), 32'd0);
            repeat (3) @(posedge clk);
            #2 reset = 1'b0;
            repeat (3) @(posedge clk);
            check($sformatf("c%0d no_done_after_abort", g), 32'(done_cnt - d0), 32'd0);

            lat_en = 1'b1;
            run_frame(400, 1'b0);
            lat_en = 1'b0;
            fin = 1'b1;
        end
    end

    initial begin
        for (int i = 0; i < 20000 && !(gen_cfg[0].fin && gen_cfg[1].fin); i++) @(posedge clk);
        check("all_configs_finished", 32'({gen_cfg[0].fin, gen_cfg[1].fin}), 32'd3);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ofdm_cp_inserter.md
Name: ofdm_cp_inserter

Overview:
Transmit-side counterpart of the sample-timing-offset receiver path. The block buffers one OFDM symbol of NFFT samples, then emits a cyclic prefix followed by the full symbol. The cyclic prefix is the last NCP samples of the symbol. It repeats this for NSYM symbols per frame, then pulses done. It is sequenced by a go/done controller with symbol and guard counters, and sits between the IFFT output and the DAC/channel model.

Parameters:
DW, 16, sample width in bits (I/Q packed by the upstream block)
NFFT, 64, samples per OFDM symbol (useful part)
NCP, 16, cyclic-prefix length in samples; legal range 1..NFFT
NSYM, 4, symbols per frame; legal range ≥1

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high; clears state, counters and outputs
go  input  1  frame start request; sampled only in IDLE
in_data  input  DW  symbol sample from IFFT
in_valid  input  1  in_data valid
in_ready  output  1  block accepts in_data this cycle
out_data  output  DW  transmitted sample (CP or body)
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts out_data this cycle
busy  output  1  high from leaving IDLE until DONE completes
done  output  1  one-cycle pulse after the last sample of symbol NSYM is accepted

Behaviour:
- Reset: the FSM goes to IDLE. All counters are 0. in_ready, out_valid, busy and done are 0. out_data is 0. Buffer contents are undefined and not cleared.
- Storage: NFFT x DW register array. Write pointer and read pointer are $clog2(NFFT) bits wide.
- The sym_cnt counter covers 0..NSYM-1. The samp_cnt counter covers 0..NFFT-1.
- Transfers: an input transfer occurs when in_valid&in_ready. An output transfer occurs when out_valid&out_ready.
- FSM states: IDLE, INIT, LOAD, CP, BODY, NEXT, DONE.
- IDLE: all outputs 0. go=1 moves to INIT next cycle. go in any other state is ignored.
- INIT: one cycle. Clears sym_cnt, samp_cnt and both pointers. busy=1. Moves to LOAD.
- LOAD:
  - in_ready=1. Each input transfer writes mem[wr_ptr] and increments wr_ptr.
  - The transfer with wr_ptr=NFFT-1 moves to CP and sets rd_ptr=NFFT-NCP.
  - in_valid=0 stalls the state with no change.
- CP:
  - out_valid=1. out_data=mem[rd_ptr] (combinational read, zero latency).
  - Each output transfer increments rd_ptr.
  - The transfer at rd_ptr=NFFT-1 wraps rd_ptr to 0 and moves to BODY.
  - If NCP=NFFT, CP starts at rd_ptr=0.
- BODY:
  - out_valid=1. out_data=mem[rd_ptr]. Each output transfer increments rd_ptr.
  - The transfer at rd_ptr=NFFT-1 moves to NEXT.
- NEXT: one cycle, no transfers.
  - If sym_cnt=NSYM-1, move to DONE.
  - Otherwise increment sym_cnt, clear wr_ptr, and move to LOAD.
- DONE: done=1 for exactly one cycle, busy=0. Moves to IDLE.
- Backpressure:
  - out_ready=0 in CP or BODY holds out_data, out_valid and rd_ptr stable.
  - in_ready is 0 in every state except LOAD. Loading and emitting never overlap.
- Output count per frame is exactly NSYM*(NCP+NFFT) samples. Input count per frame is exactly NSYM*NFFT samples.
- Minimum frame latency with in_valid and out_ready held high: go to done = 1 (INIT) + NSYM*(NFFT + NCP + NFFT + 1) + 1 cycles.
- Reset asserted mid-frame forces IDLE asynchronously, and outputs drop immediately. No done pulse is issued. A new go after reset release starts a fresh frame.
- Arithmetic: pointers are unsigned and wrap modulo NFFT. The value NFFT-NCP is a parameter constant, computed at elaboration.

Optional Feature:
Macro CP_FLAG_EN.
- When defined, an extra output port out_cp (1 bit) is added. It is high while in CP with out_valid=1, and 0 otherwise, including at reset.
- An extra output out_sos (1 bit) is also added. It is high on the first CP sample of each symbol while out_valid=1.
- When not defined, neither port exists and all other behaviour is identical.

Test Plan:
- NFFT=8, NCP=2, NSYM=1; go, then feed 0..7 with out_ready=1 → out sequence 6,7,0,1,2,3,4,5,6,7; done pulses once, 1 cycle after the last accepted output; busy drops the same cycle.
- Defaults, in_data=ramp per symbol (s*64+k), NSYM=4 → 320 outputs; each symbol starts with s*64+48..s*64+63, then s*64+0..63; exactly one done.
- NFFT=8, NCP=2; toggle out_ready every other cycle during CP/BODY → out_data and rd_ptr stable while out_ready=0; sequence unchanged; 10 transfers total.
- NCP=NFFT=4 → output 0,1,2,3,0,1,2,3 per symbol; go pulsed during LOAD ignored; in_valid gaps stall LOAD without lost samples.
- Assert reset mid-BODY of symbol 2 → out_valid, in_ready, busy go to 0 asynchronously, no done; next go restarts with sym_cnt=0 and a full 10-sample symbol.
- CP_FLAG_EN defined, NFFT=8, NCP=2, NSYM=2 → out_cp high on outputs 1-2 and 11-12 (1-indexed); out_sos high on outputs 1 and 11 only.
